// File: rtl/cordic_nco_seq_if.sv
// cordic_nco_seq_if: sequencer <-> CORDIC/mirror handshake bundle.
// start/angle/done to the CORDIC core; wen/index_qua to the mirror stage.
interface cordic_nco_seq_if #(
  parameter int ANGLE_W = 16
);
  logic               cordic_start;
  logic [ANGLE_W-1:0] cordic_angle;
  logic               cordic_done;
  logic [2:0]         index_qua;
  logic               wen;

  modport master (
    output cordic_start,
    output cordic_angle,
    output index_qua,
    output wen,
    input  cordic_done
  );

  modport slave (
    input  cordic_start,
    input  cordic_angle,
    input  index_qua,
    input  wen,
    output cordic_done
  );
endinterface

// File: rtl/cordic_nco_seq.sv
// cordic_nco_seq: NCO phase accumulator + CORDIC start/done sequencer.
// Ports: clk, reset(async low), en, freq_word, div, clr_err, bus, busy, overrun, timeout.
module cordic_nco_seq #(
  parameter int PHASE_W = 32,
  parameter int ANGLE_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [15:0]        div,
  input  logic               clr_err,
  cordic_nco_seq_if.master   bus,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE
  } state_t;

  state_t state, nxt;

  logic [15:0]        cnt;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nx;
  logic [2:0]         oct;
  logic [2:0]         oct_q;
  logic [ANGLE_W-1:0] r;
  logic [ANGLE_W-1:0] ang;
  logic [WW-1:0]      wcnt;
  logic               ov_ev;
  logic               to_ev;

  assign tick     = en && (cnt >= div);
  assign phase_nx = phase + freq_word;
  assign oct      = phase_nx[PHASE_W-1 -: 3];
  assign r        = phase_nx[PHASE_W-4 -: ANGLE_W];
  // odd octants run backwards: fold with one's complement
  assign ang      = oct[0] ? ~r : r;

  assign ov_ev = tick && (state != IDLE);
  assign to_ev = (state == WAIT) && !bus.cordic_done
              && (wcnt == TMAX);

  assign busy             = (state != IDLE);
  assign bus.cordic_start = (state == ISSUE);
  assign bus.wen          = (state == WRITE);

  // phase advances on every tick, issued or not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + 16'd1;
      if (tick) phase <= phase_nx;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (tick) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (bus.cordic_done)   nxt = WRITE;
        else if (wcnt == TMAX) nxt = IDLE;
      end
      WRITE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wcnt             <= '0;
      oct_q            <= '0;
      bus.cordic_angle <= '0;
      bus.index_qua    <= '0;
      overrun          <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ISSUE)     wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + WW'(1);
      if (state == IDLE && tick) begin
        oct_q            <= oct;
        bus.cordic_angle <= ang;
      end
      if (state == WAIT && bus.cordic_done)
        bus.index_qua <= oct_q;
      // a set event outranks a simultaneous clear
      overrun <= ov_ev | (overrun & ~clr_err);
      timeout <= to_ev | (timeout & ~clr_err);
    end
  end

endmodule

// File: tb/tb_cordic_nco_seq.sv
// tb_cordic_nco_seq: bench for cordic_nco_seq with a CORDIC response model.
// Table vectors, directed corner sequences and randomized arithmetic reference.
module tb_cordic_nco_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] freq_word = '0;
  logic [15:0] div = '0;
  logic        busy, overrun, timeout;

  always #5 clk = ~clk;

  cordic_nco_seq_if #(.ANGLE_W(16)) ifc ();

  cordic_nco_seq #(
    .PHASE_W(32),
    .ANGLE_W(16),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .freq_word(freq_word),
    .div(div),
    .clr_err(clr_err),
    .bus(ifc),
    .busy(busy),
    .overrun(overrun),
    .timeout(timeout)
  );

  int total = 0;
  int bad = 0;
  int done_delay = 0;
  logic mdl_done = 1'b0;
  logic stray_done = 1'b0;
  int cyc = 0;
  logic [15:0] alog[$];
  int          slog[$];
  logic [2:0]  wlog[$];
  int ab, wb, t0;

  assign ifc.cordic_done = mdl_done | stray_done;

  // CORDIC model: done pulse done_delay cycles after the start cycle
  initial begin : cordic_model
    int pend;
    pend = 0;
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (!reset) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) mdl_done = 1'b1;
      end
      if (reset && ifc.cordic_start && done_delay > 0)
        pend = done_delay;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (ifc.cordic_start) begin
        alog.push_back(ifc.cordic_angle);
        slog.push_back(cyc);
      end
      if (ifc.wen) wlog.push_back(ifc.index_qua);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    clr_err = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_start(input int target, input int budget,
                            input string nm);
    int c = 0;
    while (alog.size() < target && c < budget) begin
      step(1);
      c++;
    end
    chk(nm, 32'(alog.size() >= target), 32'd1);
  endtask

  task automatic wait_wen(input int target, input int budget,
                          input string nm);
    int c = 0;
    while (wlog.size() < target && c < budget) begin
      step(1);
      c++;
    end
    chk(nm, 32'(wlog.size() >= target), 32'd1);
  endtask

  // reference: octant = phase / 2^29, r = (phase mod 2^29) / 2^13
  function automatic logic [2:0] ref_oct(input logic [31:0] p);
    return 3'(p / 32'h2000_0000);
  endfunction

  function automatic logic [15:0] ref_ang(input logic [31:0] p);
    int unsigned o, rr;
    o = p / 32'h2000_0000;
    rr = (p % 32'h2000_0000) / 32'h2000;
    if (o % 2 == 1) rr = 65535 - rr;
    return 16'(rr);
  endfunction

  typedef struct {
    logic [31:0] freq;
    logic [15:0] dv;
    int          n;
    logic [2:0]  oct;
    logic [15:0] ang;
  } vec_t;

  vec_t tbl[8];

  initial begin : main
    logic [2:0] seq[5];
    logic [31:0] f, p;
    int dv;

    tbl[0] = '{32'h1000_0000, 16'd20, 1, 3'd0, 16'h8000};
    tbl[1] = '{32'h1000_0000, 16'd20, 2, 3'd1, 16'hFFFF};
    tbl[2] = '{32'h1000_0000, 16'd20, 3, 3'd1, 16'h7FFF};
    tbl[3] = '{32'h1000_0000, 16'd20, 5, 3'd2, 16'h8000};
    tbl[4] = '{32'h1234_5678, 16'd15, 1, 3'd0, 16'h91A2};
    tbl[5] = '{32'h1234_5678, 16'd15, 2, 3'd1, 16'hDCBA};
    tbl[6] = '{32'hF000_0000, 16'd10, 1, 3'd7, 16'h7FFF};
    tbl[7] = '{32'hFFFF_FFFF, 16'd7,  1, 3'd7, 16'h0000};
    seq = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1};

    // reset state
    do_reset();
    chk("rst_outputs", {8'h0, ifc.cordic_start, ifc.wen, busy, overrun,
        timeout, ifc.index_qua, ifc.cordic_angle}, 32'h0);

    // decomposition table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      freq_word = tbl[i].freq;
      div = tbl[i].dv;
      done_delay = 3;
      ab = alog.size();
      wb = wlog.size();
      en = 1'b1;
      wait_start(ab + tbl[i].n, (tbl[i].dv + 1) * (tbl[i].n + 1) + 20,
                 $sformatf("tbl%0d_start", i));
      if (alog.size() >= ab + tbl[i].n)
        chk($sformatf("tbl%0d_angle", i), alog[ab+tbl[i].n-1], tbl[i].ang);
      wait_wen(wb + tbl[i].n, 40, $sformatf("tbl%0d_wen", i));
      if (wlog.size() >= wb + tbl[i].n)
        chk($sformatf("tbl%0d_idx", i), wlog[wb+tbl[i].n-1], tbl[i].oct);
      en = 1'b0;
    end

    // overrun: div=3, done 5 cycles after start
    do_reset();
    freq_word = 32'h2000_0000;
    div = 16'd3;
    done_delay = 5;
    ab = alog.size();
    wb = wlog.size();
    en = 1'b1;
    wait_start(ab + 1, 20, "ovr_first_start");
    chk("ovr_clear_at_first", overrun, 0);
    wait_wen(wb + 5, 120, "ovr_wen5");
    for (int k = 0; k < 5; k++)
      if (wlog.size() > wb + k)
        chk($sformatf("ovr_idx%0d", k), wlog[wb+k], seq[k]);
    for (int k = 1; k < 5; k++)
      if (slog.size() > ab + k)
        chk($sformatf("ovr_gap%0d", k), slog[ab+k] - slog[ab+k-1], 8);
    chk("ovr_flag", overrun, 1);
    en = 1'b0;
    step(20);
    chk("ovr_idle", busy, 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("ovr_clr", overrun, 0);

    // timeout: CORDIC never answers
    do_reset();
    freq_word = 32'h2000_0000;
    div = 16'd10;
    done_delay = 0;
    ab = alog.size();
    wb = wlog.size();
    en = 1'b1;
    wait_start(ab + 1, 30, "to_start");
    en = 1'b0;
    step(64);
    chk("to_not_yet", timeout, 0);
    chk("to_busy_wait", busy, 1);
    step(1);
    chk("to_set", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_no_wen", wlog.size() - wb, 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("to_clr", timeout, 0);

    // accumulator wrap 0xF000_0000 + 0x2000_0000
    do_reset();
    freq_word = 32'hF000_0000;
    div = 16'd30;
    done_delay = 2;
    ab = alog.size();
    wb = wlog.size();
    en = 1'b1;
    wait_start(ab + 1, 60, "wrap_start1");
    freq_word = 32'h2000_0000;
    wait_start(ab + 2, 60, "wrap_start2");
    if (alog.size() >= ab + 2) begin
      chk("wrap_ang1", alog[ab], 16'h7FFF);
      chk("wrap_ang2", alog[ab+1], 16'h8000);
    end
    wait_wen(wb + 2, 20, "wrap_wen2");
    if (wlog.size() >= wb + 2) chk("wrap_idx", wlog[wb+1], 0);
    chk("wrap_flags", {overrun, timeout}, 0);
    en = 1'b0;

    // reset during WAIT
    do_reset();
    freq_word = 32'h2000_0000;
    div = 16'd30;
    done_delay = 10;
    en = 1'b1;
    wait_start(alog.size() + 1, 60, "rw_start");
    step(3);
    reset = 1'b0;
    #1;
    chk("rw_async_zero", {8'h0, ifc.cordic_start, ifc.wen, busy, overrun,
        timeout, ifc.index_qua, ifc.cordic_angle}, 32'h0);
    en = 1'b0;
    step(2);
    reset = 1'b1;
    ab = alog.size();
    wb = wlog.size();
    step(1);
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    step(15);
    chk("rw_no_wen", wlog.size() - wb, 0);
    chk("rw_no_start", alog.size() - ab, 0);
    chk("rw_idle", busy, 0);

    // en dropped mid-WAIT
    do_reset();
    freq_word = 32'h2000_0000;
    div = 16'd5;
    done_delay = 6;
    ab = alog.size();
    wb = wlog.size();
    en = 1'b1;
    wait_start(ab + 1, 20, "en_start");
    step(2);
    en = 1'b0;
    step(30);
    chk("en_one_wen", wlog.size() - wb, 1);
    chk("en_no_start", alog.size() - ab, 1);
    chk("en_idle", busy, 0);
    div = 16'd2;
    t0 = cyc;
    en = 1'b1;
    wait_start(ab + 2, 10, "en_restart");
    if (slog.size() >= ab + 2)
      chk("en_restart_lat", slog[ab+1] - t0, 3);
    en = 1'b0;
    step(10);

    // randomized frequency, prescaler and CORDIC latency
    for (int t = 0; t < 4; t++) begin
      do_reset();
      f = $urandom;
      dv = $urandom_range(12, 30);
      freq_word = f;
      div = 16'(dv);
      done_delay = $urandom_range(1, 8);
      ab = alog.size();
      wb = wlog.size();
      en = 1'b1;
      wait_wen(wb + 6, (dv + 1) * 8 + 40, $sformatf("rnd%0d_wen", t));
      for (int k = 0; k < 6; k++) begin
        if (wlog.size() > wb + k && alog.size() > ab + k) begin
          p = f * 32'(k + 1);
          chk($sformatf("rnd%0d_ang%0d", t, k), alog[ab+k], ref_ang(p));
          chk($sformatf("rnd%0d_idx%0d", t, k), wlog[wb+k], ref_oct(p));
          if (k > 0)
            chk($sformatf("rnd%0d_gap%0d", t, k),
                slog[ab+k] - slog[ab+k-1], dv + 1);
        end
      end
      chk($sformatf("rnd%0d_flags", t), {overrun, timeout}, 0);
      en = 1'b0;
      step(20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_nco_seq.md
Name: cordic_nco_seq

Overview:
- Sequencer for the sine-generation datapath: NCO phase accumulator, octant decomposition, start/done handshake to an iterative CORDIC core, and write-strobe/octant issue to the quadrant-mirror stage.
- Sits between the control registers and the CORDIC + mirror pair; guarantees index_qua is aligned with the CORDIC result it belongs to.

Parameters:
- PHASE_W, 32, phase accumulator and freq_word width
- ANGLE_W, 16, CORDIC angle input width (ANGLE_W <= PHASE_W-3)
- TIMEOUT, 64, max cycles waiting for cordic_done before abort

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- en  input  1  run enable
- freq_word  input  PHASE_W  phase increment per sample tick
- div  input  16  sample prescaler; tick every div+1 cycles
- clr_err  input  1  clears overrun and timeout flags
- cordic_start  output  1  one-cycle start pulse to CORDIC
- cordic_angle  output  ANGLE_W  folded first-octant angle
- cordic_done  input  1  CORDIC result valid (one-cycle pulse)
- index_qua  output  3  octant index for mirror stage
- wen  output  1  one-cycle write strobe to mirror stage
- busy  output  1  FSM not in IDLE
- overrun  output  1  sticky: tick arrived while busy
- timeout  output  1  sticky: CORDIC did not answer in TIMEOUT cycles

Behaviour:
- Reset (async, reset=0): all registers 0; state IDLE; every output 0.
- Prescaler: cnt increments each clk while en=1; tick when cnt >= div, cnt -> 0 same edge. en=0: cnt held at 0, no ticks. div=0: tick every cycle. div reduced below cnt: tick on next cycle.
- Accumulator: on every tick, phase <= phase + freq_word, modulo 2^PHASE_W (wraps silently), regardless of FSM state; keeps phase continuity when ticks are dropped.
- Decomposition of the post-increment phase: oct = phase[PHASE_W-1:PHASE_W-3]; r = next ANGLE_W bits below oct. Angle = oct[0] ? ~r : r (one's complement fold).
- FSM:
  - IDLE: on tick, latch oct into oct_q and angle into cordic_angle -> ISSUE.
  - ISSUE: cordic_start=1 for exactly one cycle; clear wait counter -> WAIT.
  - WAIT: on cordic_done -> WRITE. If the wait counter reaches TIMEOUT-1 without done, set timeout -> IDLE (no wen).
  - WRITE: wen=1 for one cycle, index_qua=oct_q -> IDLE.
- Timing: tick at edge N -> cordic_start high in cycle N+1. cordic_done in cycle M -> wen and index_qua valid in cycle M+1.
- index_qua and cordic_angle hold their last values between operations.
- busy = (state != IDLE).
- Overrun: a tick while state != IDLE sets overrun and is not issued. A tick in the same cycle the FSM returns to IDLE is also dropped.
- cordic_done outside WAIT is ignored.
- clr_err clears both flags. A set event in the same cycle as clr_err wins (flag stays 1).
- en deasserted mid-operation: current op completes normally; no new ticks.
- Reset mid-operation: immediate return to IDLE; no cordic_start or wen pulse is generated on reset release.

Test Plan:
- Reset, en=1, div=3, freq_word=0x2000_0000, CORDIC model done 5 cycles after start -> ticks every 4 cycles; issue completes 1 tick in 2 (ISSUE/WAIT/WRITE span 8 cycles) with overrun=1 from the first dropped tick; written index_qua sequence 1,3,5,7,1...
- freq_word=0x1000_0000, div=20 -> phases 0x1000_0000, 0x2000_0000...; at 0x3000_0000: oct=1, r=0x8000, cordic_angle=0x7FFF; at 0x5000_0000: oct=2, angle=0x8000.
- CORDIC model never asserts done, TIMEOUT=64 -> timeout=1 at 64 cycles after start, no wen, FSM back in IDLE; clr_err pulse -> flag 0.
- Accumulator at 0xF000_0000 + 0x2000_0000 -> 0x1000_0000, index_qua=0, no error flags.
- Assert reset during WAIT -> all outputs 0 asynchronously; no wen after release; a stray cordic_done is ignored.
- en=0 mid-WAIT -> wen still issued once; then no cordic_start while en=0; cnt holds 0.
